guess_with_dice: RTL and testbench

GUESS_WITH_DICE -- requirements
Module: guess_with_dice

---
 rtl/guess_with_dice.sv | 170 +++++++++++++++++
 tb/tb_guess_with_dice.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/guess_with_dice.sv
// Two-player "pig" dice game: roll to build a turn sum, hold to bank it.
// Ports: CLK/RESET, NEW_GAME, ROLL, HOLD, lfsr_result[6:0] -> 7-seg digits, P1/P2.
module guess_with_dice (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       NEW_GAME,
  input  logic       ROLL,
  input  logic       HOLD,
  input  logic [6:0] lfsr_result,
  output logic [6:0] seg1_1,
  output logic [6:0] seg1_10,
  output logic [6:0] seg2_1,
  output logic [6:0] seg2_10,
  output logic [6:0] segsum_1,
  output logic [6:0] segsum_10,
  output logic [6:0] segdice,
  output logic       P1,
  output logic       P2
);

  typedef enum logic [1:0] {
    TURN_P1,
    TURN_P2,
    OVER
  } state_e;

  localparam logic [6:0] MAX_VAL = 7'd99;
  localparam logic [6:0] WIN_VAL = 7'd50;
  localparam logic [6:0] BLANK   = 7'b1111111;

  state_e     state_q, state_d;
  logic [6:0] total1_q, total1_d;
  logic [6:0] total2_q, total2_d;
  logic [6:0] turn_sum_q, turn_sum_d;
  logic [2:0] die_q, die_d;
  logic       winner1_q, winner1_d;
  logic       roll_prev_q, roll_prev_d;
  logic       hold_prev_q, hold_prev_d;

  logic       roll_fire;
  logic       hold_fire;
  logic [2:0] die_val;
  logic [7:0] sum_add;
  logic [6:0] sum_sat;
  logic [6:0] active_total;
  logic [7:0] bank_add;
  logic [6:0] bank_sat;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= TURN_P1;
      total1_q    <= '0;
      total2_q    <= '0;
      turn_sum_q  <= '0;
      die_q       <= '0;
      winner1_q   <= 1'b0;
      roll_prev_q <= 1'b0;
      hold_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      total1_q    <= total1_d;
      total2_q    <= total2_d;
      turn_sum_q  <= turn_sum_d;
      die_q       <= die_d;
      winner1_q   <= winner1_d;
      roll_prev_q <= roll_prev_d;
      hold_prev_q <= hold_prev_d;
    end
  end

  // Datapath helpers: die face, saturating turn sum, saturating bank.
  always_comb begin
    roll_fire    = ROLL & ~roll_prev_q;
    hold_fire    = HOLD & ~hold_prev_q;
    die_val      = 3'(lfsr_result % 7'd6) + 3'd1;
    sum_add      = {1'b0, turn_sum_q} + {5'b0, die_val};
    sum_sat      = (sum_add > {1'b0, MAX_VAL}) ? MAX_VAL : sum_add[6:0];
    active_total = (state_q == TURN_P2) ? total2_q : total1_q;
    bank_add     = {1'b0, active_total} + {1'b0, turn_sum_q};
    bank_sat     = (bank_add > {1'b0, MAX_VAL}) ? MAX_VAL : bank_add[6:0];
  end

  always_comb begin
    state_d     = state_q;
    total1_d    = total1_q;
    total2_d    = total2_q;
    turn_sum_d  = turn_sum_q;
    die_d       = die_q;
    winner1_d   = winner1_q;
    roll_prev_d = ROLL;
    hold_prev_d = HOLD;

    if (NEW_GAME) begin
      state_d     = TURN_P1;
      total1_d    = '0;
      total2_d    = '0;
      turn_sum_d  = '0;
      die_d       = '0;
      winner1_d   = 1'b0;
      roll_prev_d = 1'b0;
      hold_prev_d = 1'b0;
    end else begin
      case (state_q)
        TURN_P1, TURN_P2: begin
          // Roll wins over a simultaneous hold.
          if (roll_fire) begin
            die_d = die_val;
            if (die_val == 3'd1) begin
              turn_sum_d = '0;
              state_d    = (state_q == TURN_P1) ? TURN_P2 : TURN_P1;
            end else begin
              turn_sum_d = sum_sat;
            end
          end else if (hold_fire) begin
            turn_sum_d = '0;
            die_d      = '0;
            if (state_q == TURN_P1) total1_d = bank_sat;
            else                    total2_d = bank_sat;
            if (bank_sat >= WIN_VAL) begin
              state_d   = OVER;
              winner1_d = (state_q == TURN_P1);
            end else begin
              state_d = (state_q == TURN_P1) ? TURN_P2 : TURN_P1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    seg1_1    = seg7(4'(total1_q % 7'd10));
    seg1_10   = seg7(4'(total1_q / 7'd10));
    seg2_1    = seg7(4'(total2_q % 7'd10));
    seg2_10   = seg7(4'(total2_q / 7'd10));
    segsum_1  = seg7(4'(turn_sum_q % 7'd10));
    segsum_10 = seg7(4'(turn_sum_q / 7'd10));
    segdice   = (die_q == 3'd0) ? BLANK : seg7({1'b0, die_q});
    P1        = 1'b0;
    P2        = 1'b0;
    case (state_q)
      TURN_P1: P1 = 1'b1;
      TURN_P2: P2 = 1'b1;
      default: begin
        P1 = winner1_q;
        P2 = ~winner1_q;
      end
    endcase
  end

endmodule

// File: tb/tb_guess_with_dice.sv
// Scoreboarded random + directed bench for guess_with_dice.
// A game-rule model predicts outputs; a monitor compares after each edge.
module tb_guess_with_dice;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       NEW_GAME = 1'b0;
  logic       ROLL = 1'b0;
  logic       HOLD = 1'b0;
  logic [6:0] lfsr_result = 7'd127;
  logic [6:0] seg1_1, seg1_10, seg2_1, seg2_10;
  logic [6:0] segsum_1, segsum_10, segdice;
  logic       P1, P2;

  guess_with_dice dut (
    .CLK(CLK), .RESET(RESET), .NEW_GAME(NEW_GAME),
    .ROLL(ROLL), .HOLD(HOLD), .lfsr_result(lfsr_result),
    .seg1_1(seg1_1), .seg1_10(seg1_10),
    .seg2_1(seg2_1), .seg2_10(seg2_10),
    .segsum_1(segsum_1), .segsum_10(segsum_10),
    .segdice(segdice), .P1(P1), .P2(P2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] s1_1, s1_10, s2_1, s2_10, ss_1, ss_10, sd;
    logic       p1, p2;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Game model: plain integers, player number 1/2, over flag.
  int m_tot1, m_tot2, m_sum, m_die, m_player, m_over, m_winner;
  bit m_pr, m_ph;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.s1_1  = seg_of(m_tot1 % 10);
    e.s1_10 = seg_of(m_tot1 / 10);
    e.s2_1  = seg_of(m_tot2 % 10);
    e.s2_10 = seg_of(m_tot2 / 10);
    e.ss_1  = seg_of(m_sum % 10);
    e.ss_10 = seg_of(m_sum / 10);
    e.sd    = (m_die == 0) ? 7'b1111111 : seg_of(m_die);
    if (m_over != 0) begin
      e.p1 = (m_winner == 1);
      e.p2 = (m_winner == 2);
    end else begin
      e.p1 = (m_player == 1);
      e.p2 = (m_player == 2);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_tot1 = 0; m_tot2 = 0; m_sum = 0; m_die = 0;
    m_player = 1; m_over = 0; m_winner = 0;
    m_pr = 0; m_ph = 0;
  endtask

  task automatic model_edge(input bit ng, input bit r, input bit h,
                            input int lf);
    bit rf, hf;
    int d, t;
    if (ng) begin
      model_reset();
      return;
    end
    rf = r && !m_pr;
    hf = h && !m_ph;
    m_pr = r;
    m_ph = h;
    if (m_over != 0) return;
    if (rf) begin
      d = (lf % 6) + 1;
      m_die = d;
      if (d == 1) begin
        m_sum = 0;
        m_player = 3 - m_player;
      end else begin
        m_sum = (m_sum + d > 99) ? 99 : m_sum + d;
      end
    end else if (hf) begin
      t = (m_player == 1) ? m_tot1 : m_tot2;
      t = (t + m_sum > 99) ? 99 : t + m_sum;
      if (m_player == 1) m_tot1 = t;
      else               m_tot2 = t;
      m_sum = 0;
      m_die = 0;
      if (t >= 50) begin
        m_over = 1;
        m_winner = m_player;
      end else begin
        m_player = 3 - m_player;
      end
    end
  endtask

  task automatic step(input bit ng, input bit r, input bit h, input int lf);
    @(negedge CLK);
    RESET = 1'b0;
    NEW_GAME = ng;
    ROLL = r;
    HOLD = h;
    lfsr_result = 7'(lf);
    model_edge(ng, r, h, lf);
    sb_q.push_back(model_out());
  endtask

  task automatic press(input bit r, input bit h, input int lf);
    step(1'b0, r, h, lf);
    step(1'b0, 1'b0, 1'b0, lf);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    sb_q.push_back(model_out());
  endtask

  task automatic chk(input string n, input logic [6:0] a,
                     input logic [6:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b t=%0t", n, a, e, $time);
    end
  endtask

  exp_t ex;
  always @(posedge CLK) begin
    #1;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      chk("seg1_1", seg1_1, ex.s1_1);
      chk("seg1_10", seg1_10, ex.s1_10);
      chk("seg2_1", seg2_1, ex.s2_1);
      chk("seg2_10", seg2_10, ex.s2_10);
      chk("segsum_1", segsum_1, ex.ss_1);
      chk("segsum_10", segsum_10, ex.ss_10);
      chk("segdice", segdice, ex.sd);
      chk("P1", {6'b0, P1}, {6'b0, ex.p1});
      chk("P2", {6'b0, P2}, {6'b0, ex.p2});
    end
  end

  initial begin
    int r, h, ng, rs, lf;
    model_reset();
    do_reset();
    do_reset();
    // Long press rolls once: die 2, then second press sums 4.
    repeat (300) step(0, 1, 0, 127);
    step(0, 0, 0, 127);
    repeat (5) step(0, 1, 0, 127);
    step(0, 0, 0, 127);
    press(0, 1, 127);
    // P2 builds 4, then rolls a 1.
    press(1, 0, 127);
    press(1, 0, 127);
    press(1, 0, 6);
    // Simultaneous roll/hold: roll only.
    press(1, 1, 127);
    press(1, 1, 6);
    press(0, 1, 127);
    // P1 to 48, then wins at 52.
    repeat (7) press(1, 0, 5);
    press(1, 0, 127);
    press(0, 1, 127);
    press(0, 1, 127);
    press(1, 0, 127);
    press(1, 0, 127);
    press(0, 1, 127);
    press(1, 0, 127);
    press(0, 1, 127);
    // New game with a coincident roll.
    step(1, 1, 0, 127);
    step(0, 0, 0, 127);
    press(1, 0, 127);
    step(1, 1, 0, 127);
    step(0, 0, 0, 127);
    // Turn-sum and total saturation at 99.
    repeat (17) press(1, 0, 5);
    press(0, 1, 127);
    // Mid-game reset with a held button across release.
    step(1, 0, 0, 127);
    press(1, 0, 127);
    @(negedge CLK);
    ROLL = 1'b1;
    RESET = 1'b1;
    model_reset();
    sb_q.push_back(model_out());
    step(0, 1, 0, 127);
    step(0, 0, 0, 127);
    // Random play.
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 99) < 35) ? 1 : 0;
      h  = ($urandom_range(0, 99) < 20) ? 1 : 0;
      ng = ($urandom_range(0, 299) == 0) ? 1 : 0;
      rs = ($urandom_range(0, 599) == 0) ? 1 : 0;
      lf = int'($urandom_range(0, 127));
      if (rs != 0) do_reset();
      else step(ng[0], r[0], h[0], lf);
    end
    step(0, 0, 0, 0);
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d expected=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
